// File: rtl/sr_drive_controller.sv
// sr_drive_controller
//
// Initiator side of an SR storage-element bank. A request (set/clear masks)
// is taken over a valid/ready handshake. The controller then pulses S/R into
// WIDTH SR flip-flops and checks the Q/Q_bar feedback. It reports the outcome
// with a one-cycle done pulse and a held error code.
//
// Ports
//   Clock      rising-edge clock
//   Reset      synchronous, active-high reset
//   req_valid  request present
//   req_ready  controller can accept a request (high only in IDLE)
//   req_set    bits to set
//   req_clr    bits to clear
//   S, R       registered set/reset drive to the bank; S & R is always zero
//   Q, Q_bar   bank feedback
//   done       one-cycle completion pulse
//   error      last operation failed; valid with done, held until next accept
//   err_code   00 ok, 01 overlap, 10 timeout, 11 Q/Q_bar inconsistent
//
// Timing, with accept at edge E0:
//   - S/R are high from E0 to E(PULSE_CYCLES).
//   - The first feedback check happens at E(PULSE_CYCLES+1).
//   - done is high for the cycle that follows the deciding edge.
//   - Overlapping or empty requests decide at the accept edge itself.
module sr_drive_controller #(
    parameter int WIDTH        = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int TIMEOUT      = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_set,
    input  logic [WIDTH-1:0] req_clr,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] Q_bar,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);

    localparam int PW = $clog2(PULSE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_OVERLAP = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_INCONS  = 2'b11;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    pcnt, pcnt_nx;
    logic [TW-1:0]    tcnt, tcnt_nx;
    logic [WIDTH-1:0] set_m, clr_m, set_nx, clr_nx;
    logic [WIDTH-1:0] s_nx, r_nx;
    logic             done_nx, error_nx;
    logic [1:0]       code_nx;

    // Feedback is good when every set bit reads 1 and every cleared bit
    // reads 0. Q_bar must also be the complement of Q on those bits.
    // Bits outside the request are don't-care.
    function automatic logic fb_pass(input logic [WIDTH-1:0] q,
                                     input logic [WIDTH-1:0] qb,
                                     input logic [WIDTH-1:0] sm,
                                     input logic [WIDTH-1:0] cm);
        logic [WIDTH-1:0] aff;
        aff = sm | cm;
        return ((q & sm) == sm) && ((q & cm) == '0) && (((qb ^ ~q) & aff) == '0);
    endfunction

    // An affected bit whose Q equals Q_bar points to a broken element
    // rather than a slow one.
    function automatic logic fb_incons(input logic [WIDTH-1:0] q,
                                       input logic [WIDTH-1:0] qb,
                                       input logic [WIDTH-1:0] aff);
        return ((q ~^ qb) & aff) != '0;
    endfunction

    assign req_ready = (state == IDLE);

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        tcnt_nx  = tcnt;
        set_nx   = set_m;
        clr_nx   = clr_m;
        s_nx     = S;
        r_nx     = R;
        done_nx  = 1'b0;
        error_nx = error;
        code_nx  = err_code;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    set_nx   = req_set;
                    clr_nx   = req_clr;
                    pcnt_nx  = '0;
                    tcnt_nx  = '0;
                    error_nx = 1'b0;
                    code_nx  = CODE_OK;
                    if ((req_set & req_clr) != '0) begin
                        // Conflicting masks are rejected without driving anything.
                        error_nx = 1'b1;
                        code_nx  = CODE_OVERLAP;
                        done_nx  = 1'b1;
                        state_nx = RESP;
                    end else if ((req_set | req_clr) == '0) begin
                        done_nx  = 1'b1;
                        state_nx = RESP;
                    end else begin
                        s_nx     = req_set;
                        r_nx     = req_clr;
                        pcnt_nx  = PW'(1);
                        state_nx = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (pcnt == PULSE_LAST) begin
                    s_nx     = '0;
                    r_nx     = '0;
                    state_nx = CHECK;
                end else begin
                    pcnt_nx = pcnt + PW'(1);
                end
            end
            CHECK: begin
                if (fb_pass(Q, Q_bar, set_m, clr_m)) begin
                    done_nx  = 1'b1;
                    state_nx = RESP;
                end else if (tcnt == TO_LAST) begin
                    done_nx  = 1'b1;
                    error_nx = 1'b1;
                    code_nx  = fb_incons(Q, Q_bar, set_m | clr_m) ? CODE_INCONS : CODE_TIMEOUT;
                    state_nx = RESP;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Control and drive registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            pcnt     <= '0;
            tcnt     <= '0;
            S        <= '0;
            R        <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= CODE_OK;
        end else begin
            state    <= state_nx;
            pcnt     <= pcnt_nx;
            tcnt     <= tcnt_nx;
            S        <= s_nx;
            R        <= r_nx;
            done     <= done_nx;
            error    <= error_nx;
            err_code <= code_nx;
        end
    end

    // Request masks: data only, always rewritten at accept
    always_ff @(posedge Clock) begin
        set_m <= set_nx;
        clr_m <= clr_nx;
    end

endmodule

// File: tb/tb_sr_drive_controller.sv
module tb_sr_drive_controller;

    localparam int W  = 4;
    localparam int P  = 2;
    localparam int TO = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_set, req_clr;
    logic [W-1:0] S, R, Q, Q_bar;
    logic         done, error;
    logic [1:0]   err_code;

    int n_assert = 0;
    int n_fail   = 0;

    // SR bank model with fault injection
    logic [W-1:0] bank_q = '0;
    logic [W-1:0] stuck0 = '0;   // Q forced 0, Q_bar 1
    logic [W-1:0] both1  = '0;   // Q and Q_bar both forced 1
    logic [W-1:0] mq     = '0;   // predicted underlying bank contents

    always #5 Clock = ~Clock;

    always @(posedge Clock) bank_q <= (bank_q | (S & ~R)) & ~(R & ~S);
    assign Q     = (bank_q & ~stuck0) | both1;
    assign Q_bar = ~Q | both1;

    sr_drive_controller #(.WIDTH(W), .PULSE_CYCLES(P), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_set(req_set), .req_clr(req_clr),
        .S(S), .R(R), .Q(Q), .Q_bar(Q_bar),
        .done(done), .error(error), .err_code(err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request, then predicts its outcome from the bank contents
    // and the fault masks. It checks drive, latency, done, error and code.
    task automatic run_req(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W-1:0] aff, qr, qb;
        logic [1:0]   exp_code;
        int           exp_lat;
        int           got;
        bit           drive;
        aff   = s | c;
        drive = 0;
        if ((s & c) != '0) begin
            exp_lat = 0; exp_code = 2'b01;
        end else if (aff == '0) begin
            exp_lat = 0; exp_code = 2'b00;
        end else begin
            drive = 1;
            mq = (mq | s) & ~c;
            qr = (mq & ~stuck0) | both1;
            qb = ~qr | both1;
            if (((qr & s) == s) && ((qr & c) == '0) && (((qb ^ ~qr) & aff) == '0)) begin
                exp_lat = P + 1; exp_code = 2'b00;
            end else begin
                exp_lat  = P + TO;
                exp_code = (((qr ~^ qb) & aff) != '0) ? 2'b11 : 2'b10;
            end
        end

        @(negedge Clock);
        req_valid = 1'b1; req_set = s; req_clr = c;
        check("ready_idle", req_ready, 1);
        @(posedge Clock); #1;
        req_valid = 1'b0; req_set = '0; req_clr = '0;

        got = -1;
        for (int k = 0; k <= P + TO + 4 && got < 0; k++) begin
            check("s_and_r", S & R, 0);
            check("ready_busy", req_ready, 0);
            if (drive && k < P) begin
                check("s_drive", S, s);
                check("r_drive", R, c);
            end else begin
                check("s_quiet", S, 0);
                check("r_quiet", R, 0);
            end
            if (done === 1'b1) begin
                got = k;
                check("err_code", err_code, exp_code);
                check("error", error, exp_code != 2'b00);
            end else begin
                check("error_busy", error, 0);
                @(posedge Clock); #1;
            end
        end
        check("latency", got, exp_lat);

        @(posedge Clock); #1;
        check("done_single", done, 0);
        check("ready_after", req_ready, 1);
        check("error_held", error, exp_code != 2'b00);
        check("code_held", err_code, exp_code);
        check("bank_q", bank_q, mq);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rs, rc;
        int bi, bj;

        Reset = 1'b1; req_valid = 1'b0; req_set = '0; req_clr = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_S", S, 0);
        check("rst_R", R, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_code", err_code, 0);
        check("rst_ready", req_ready, 1);
        @(negedge Clock); Reset = 1'b0;

        // Directed cases
        run_req(4'b0001, 4'b0000);
        run_req(4'b1111, 4'b0000);
        run_req(4'b0000, 4'b0110);
        check("bank_1001", bank_q, 4'b1001);
        run_req(4'b0011, 4'b0010);
        run_req(4'b0000, 4'b0000);
        stuck0 = 4'b0100;
        run_req(4'b0100, 4'b0000);
        stuck0 = '0;
        both1 = 4'b0010;
        run_req(4'b0000, 4'b0010);
        both1 = '0;
        // Back-to-back at the earliest accept
        run_req(4'b0101, 4'b0000);
        run_req(4'b0000, 4'b0101);

        // Reset while driving
        @(negedge Clock);
        req_valid = 1'b1; req_set = 4'b1000; req_clr = 4'b0001;
        @(posedge Clock); #1;
        req_valid = 1'b0; req_set = '0; req_clr = '0;
        check("rstd_S", S, 4'b1000);
        check("rstd_R", R, 4'b0001);
        mq = (mq | 4'b1000) & ~4'b0001;
        @(negedge Clock); Reset = 1'b1;
        @(posedge Clock); #1;
        check("rstd_S0", S, 0);
        check("rstd_R0", R, 0);
        check("rstd_done", done, 0);
        check("rstd_ready", req_ready, 1);
        @(negedge Clock); Reset = 1'b0;
        for (int k = 0; k < P + TO + 2; k++) begin
            @(posedge Clock); #1;
            check("rstd_no_done", done, 0);
            check("rstd_quiet", S | R, 0);
        end
        check("rstd_bank", bank_q, mq);

        // Randomized requests with occasional faults
        for (int n = 0; n < 40; n++) begin
            stuck0 = '0; both1 = '0;
            if ($urandom_range(0, 3) == 0) begin
                bi = $urandom_range(0, W - 1);
                bj = $urandom_range(0, W - 1);
                stuck0[bi] = 1'b1;
                if (bj != bi && $urandom_range(0, 1) == 1) both1[bj] = 1'b1;
            end
            rs = W'($urandom);
            rc = W'($urandom);
            if ($urandom_range(0, 4) != 0) rc = rc & ~rs;
            run_req(rs, rc);
        end
        stuck0 = '0; both1 = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
